// File: rtl/inst_ram_boot_loader.sv
// Boot loader: packs a length-prefixed byte stream into 32-bit words and writes them to instruction RAM
// while holding the CPU in reset. Optional trailing checksum byte when BOOT_CHECKSUM_EN is defined.
module inst_ram_boot_loader #(
    parameter int          IDX_W     = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        debug,
    output logic        inst_ram_write_enable,
    output logic [31:0] inst_ram_write_data,
    output logic [31:0] inst_ram_write_address,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd5;
`endif
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERROR = 3'd7;

    localparam int unsigned MAX_WORDS = 2 ** IDX_W;

    logic [2:0]       state, nxt;
    logic [IDX_W-1:0] idx;
    logic [1:0]       byte_cnt;
    logic [7:0]       len_lo;
    logic [15:0]      len;
    logic [15:0]      len_now;
    logic [23:0]      word_lo;
    logic             accept;
    logic             nxt_rx;
    logic             nxt_busy;
    logic             more_words;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]       sum;
    logic [7:0]       sum_nxt;
`endif

    assign accept     = rx_valid && rx_ready;
    assign len_now    = {rx_data, len_lo};
    assign more_words = (32'(idx) + 32'd1) < 32'(len);

    always_comb begin
        nxt = state;
`ifdef BOOT_CHECKSUM_EN
        sum_nxt = sum + rx_data;
`endif
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) nxt = S_LEN0;
            S_LEN0: if (accept) nxt = S_LEN1;
            S_LEN1: if (accept) begin
                if (len_now == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                    nxt = S_CSUM;
`else
                    nxt = S_DONE;
`endif
                end else if (32'(len_now) > MAX_WORDS) begin
                    nxt = S_ERROR;
                end else begin
                    nxt = S_DATA;
                end
            end
            S_DATA: if (accept && byte_cnt == 2'd3) nxt = S_WRITE;
            S_WRITE: begin
                if (more_words) nxt = S_DATA;
`ifdef BOOT_CHECKSUM_EN
                else nxt = S_CSUM;
`else
                else nxt = S_DONE;
`endif
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: if (accept) nxt = (sum_nxt == 8'h00) ? S_DONE : S_ERROR;
`endif
            default: nxt = S_IDLE;
        endcase

        nxt_rx = (nxt == S_LEN0) || (nxt == S_LEN1) || (nxt == S_DATA);
`ifdef BOOT_CHECKSUM_EN
        nxt_rx = nxt_rx || (nxt == S_CSUM);
`endif
        nxt_busy = nxt_rx || (nxt == S_WRITE);
    end

    // Every output is a registered function of the next state, so flags line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                  <= S_IDLE;
            idx                    <= '0;
            byte_cnt               <= 2'd0;
            len_lo                 <= 8'h00;
            len                    <= 16'h0000;
            word_lo                <= 24'h0;
            rx_ready               <= 1'b0;
            debug                  <= 1'b0;
            busy                   <= 1'b0;
            cpu_reset              <= 1'b1;
            done                   <= 1'b0;
            error                  <= 1'b0;
            inst_ram_write_enable  <= 1'b0;
            inst_ram_write_data    <= 32'h0;
            inst_ram_write_address <= BASE_ADDR;
`ifdef BOOT_CHECKSUM_EN
            sum                    <= 8'h00;
`endif
        end else begin
            state                 <= nxt;
            rx_ready              <= nxt_rx;
            busy                  <= nxt_busy;
            debug                 <= nxt_busy;
            cpu_reset             <= (nxt != S_DONE);
            done                  <= (nxt == S_DONE);
            error                 <= (nxt == S_ERROR);
            inst_ram_write_enable <= (nxt == S_WRITE);

            if (accept) begin
`ifdef BOOT_CHECKSUM_EN
                sum <= sum_nxt;
`endif
                case (state)
                    S_LEN0: len_lo <= rx_data;
                    S_LEN1: len    <= len_now;
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_lo[7:0]   <= rx_data;
                            2'd1: word_lo[15:8]  <= rx_data;
                            2'd2: word_lo[23:16] <= rx_data;
                            2'd3: begin
                                inst_ram_write_data    <= {rx_data, word_lo};
                                inst_ram_write_address <= BASE_ADDR + 32'({idx, 2'b00});
                            end
                        endcase
                    end
                    default: ;
                endcase
            end

            if (state == S_WRITE) idx <= idx + 1'b1;

            if (nxt == S_LEN0 && state != S_LEN0) begin
                idx      <= '0;
                byte_cnt <= 2'd0;
`ifdef BOOT_CHECKSUM_EN
                sum      <= 8'h00;
`endif
            end
        end
    end

endmodule

// File: tb/tb_inst_ram_boot_loader.sv
// Bench for inst_ram_boot_loader: per-cycle vector table for the default build, plus
// hand sequences for ignored start and strobe spacing; checksum sequences when BOOT_CHECKSUM_EN is defined.
module tb_inst_ram_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        debug;
    logic        inst_ram_write_enable;
    logic [31:0] inst_ram_write_data;
    logic [31:0] inst_ram_write_address;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] st_addr[$];
    logic [31:0] st_data[$];
    int          st_cyc[$];

    inst_ram_boot_loader #(.IDX_W(10), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .debug(debug), .inst_ram_write_enable(inst_ram_write_enable),
        .inst_ram_write_data(inst_ram_write_data), .inst_ram_write_address(inst_ram_write_address),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (inst_ram_write_enable) begin
            st_addr.push_back(inst_ram_write_address);
            st_data.push_back(inst_ram_write_data);
            st_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic        rst, st, vld;
        logic [7:0]  dat;
        logic        rdy, we;
        logic [31:0] wd, wa;
        logic        cpu, dn, er, bz;
    } vec_t;

    function automatic vec_t mk(input logic rst, st, vld, input logic [7:0] dat,
                                input logic rdy, we, input logic [31:0] wd, wa,
                                input logic cpu, dn, er, bz);
        vec_t v;
        v.rst = rst; v.st = st; v.vld = vld; v.dat = dat;
        v.rdy = rdy; v.we = we; v.wd = wd; v.wa = wa;
        v.cpu = cpu; v.dn = dn; v.er = er; v.bz = bz;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_flag(input string name, input bit want_done);
        int t = 0;
        while (!(want_done ? done : error) && t < 40) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(want_done ? done : error), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

`ifndef BOOT_CHECKSUM_EN
    vec_t tbl[38];
    logic [72:0] act_v, exp_v;
    logic [7:0]  ld[10];
`endif

    initial begin
`ifndef BOOT_CHECKSUM_EN
        //          rst st vld dat     rdy we wd            wa      cpu dn er bz
        tbl[0]  = mk(1, 0, 0, 8'h00,  0, 0, 32'h0,        32'h0,  1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 8'h00,  0, 0, 32'h0,        32'h0,  1, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 8'h00,  1, 0, 32'h0,        32'h0,  1, 0, 0, 1);
        tbl[3]  = mk(0, 0, 1, 8'h02,  1, 0, 32'h0,        32'h0,  1, 0, 0, 1);
        tbl[4]  = mk(0, 0, 1, 8'h00,  1, 0, 32'h0,        32'h0,  1, 0, 0, 1);
        tbl[5]  = mk(0, 0, 1, 8'h01,  1, 0, 32'h0,        32'h0,  1, 0, 0, 1);
        tbl[6]  = mk(0, 0, 1, 8'h00,  1, 0, 32'h0,        32'h0,  1, 0, 0, 1);
        tbl[7]  = mk(0, 0, 1, 8'h01,  1, 0, 32'h0,        32'h0,  1, 0, 0, 1);
        tbl[8]  = mk(0, 0, 1, 8'h3C,  0, 1, 32'h3C010001, 32'h0,  1, 0, 0, 1);
        tbl[9]  = mk(0, 0, 1, 8'hEF,  1, 0, 32'h3C010001, 32'h0,  1, 0, 0, 1);
        tbl[10] = mk(0, 0, 1, 8'hEF,  1, 0, 32'h3C010001, 32'h0,  1, 0, 0, 1);
        tbl[11] = mk(0, 0, 1, 8'hBE,  1, 0, 32'h3C010001, 32'h0,  1, 0, 0, 1);
        tbl[12] = mk(0, 0, 1, 8'hAD,  1, 0, 32'h3C010001, 32'h0,  1, 0, 0, 1);
        tbl[13] = mk(0, 0, 1, 8'hDE,  0, 1, 32'hDEADBEEF, 32'h4,  1, 0, 0, 1);
        tbl[14] = mk(0, 0, 1, 8'h55,  0, 0, 32'hDEADBEEF, 32'h4,  0, 1, 0, 0);
        tbl[15] = mk(0, 0, 0, 8'h00,  0, 0, 32'hDEADBEEF, 32'h4,  0, 1, 0, 0);
        tbl[16] = mk(0, 1, 0, 8'h00,  1, 0, 32'hDEADBEEF, 32'h4,  1, 0, 0, 1);
        tbl[17] = mk(0, 0, 1, 8'h00,  1, 0, 32'hDEADBEEF, 32'h4,  1, 0, 0, 1);
        tbl[18] = mk(0, 0, 1, 8'h00,  0, 0, 32'hDEADBEEF, 32'h4,  0, 1, 0, 0);
        tbl[19] = mk(0, 1, 0, 8'h00,  1, 0, 32'hDEADBEEF, 32'h4,  1, 0, 0, 1);
        tbl[20] = mk(0, 0, 1, 8'h01,  1, 0, 32'hDEADBEEF, 32'h4,  1, 0, 0, 1);
        tbl[21] = mk(0, 0, 1, 8'h04,  0, 0, 32'hDEADBEEF, 32'h4,  1, 0, 1, 0);
        tbl[22] = mk(0, 0, 0, 8'h00,  0, 0, 32'hDEADBEEF, 32'h4,  1, 0, 1, 0);
        tbl[23] = mk(0, 1, 0, 8'h00,  1, 0, 32'hDEADBEEF, 32'h4,  1, 0, 0, 1);
        tbl[24] = mk(0, 0, 1, 8'h01,  1, 0, 32'hDEADBEEF, 32'h4,  1, 0, 0, 1);
        tbl[25] = mk(0, 0, 1, 8'h00,  1, 0, 32'hDEADBEEF, 32'h4,  1, 0, 0, 1);
        tbl[26] = mk(0, 0, 1, 8'h11,  1, 0, 32'hDEADBEEF, 32'h4,  1, 0, 0, 1);
        tbl[27] = mk(0, 0, 1, 8'h22,  1, 0, 32'hDEADBEEF, 32'h4,  1, 0, 0, 1);
        tbl[28] = mk(1, 0, 0, 8'h00,  0, 0, 32'h0,        32'h0,  1, 0, 0, 0);
        tbl[29] = mk(0, 0, 0, 8'h00,  0, 0, 32'h0,        32'h0,  1, 0, 0, 0);
        tbl[30] = mk(0, 1, 0, 8'h00,  1, 0, 32'h0,        32'h0,  1, 0, 0, 1);
        tbl[31] = mk(0, 0, 1, 8'h01,  1, 0, 32'h0,        32'h0,  1, 0, 0, 1);
        tbl[32] = mk(0, 0, 1, 8'h00,  1, 0, 32'h0,        32'h0,  1, 0, 0, 1);
        tbl[33] = mk(0, 0, 1, 8'h78,  1, 0, 32'h0,        32'h0,  1, 0, 0, 1);
        tbl[34] = mk(0, 0, 1, 8'h56,  1, 0, 32'h0,        32'h0,  1, 0, 0, 1);
        tbl[35] = mk(0, 0, 1, 8'h34,  1, 0, 32'h0,        32'h0,  1, 0, 0, 1);
        tbl[36] = mk(0, 0, 1, 8'h12,  0, 1, 32'h12345678, 32'h0,  1, 0, 0, 1);
        tbl[37] = mk(0, 0, 0, 8'h00,  0, 0, 32'h12345678, 32'h0,  0, 1, 0, 0);

        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            reset    = tbl[i].rst;
            start    = tbl[i].st;
            rx_valid = tbl[i].vld;
            rx_data  = tbl[i].dat;
            @(posedge clk);
            #1;
            act_v = {rx_ready, inst_ram_write_enable, inst_ram_write_data, inst_ram_write_address,
                     cpu_reset, done, error, busy, debug};
            exp_v = {tbl[i].rdy, tbl[i].we, tbl[i].wd, tbl[i].wa,
                     tbl[i].cpu, tbl[i].dn, tbl[i].er, tbl[i].bz, tbl[i].bz};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL vec%0d: got %h expected %h", i, act_v, exp_v);
            end
        end
        rx_valid = 1'b0;
        start    = 1'b0;

        // Reload with start held high through the load: it must be ignored until DONE.
        st_addr.delete(); st_data.delete(); st_cyc.delete();
        ld = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h01, 8'h3C, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 10; i++) send_byte(ld[i]);
        start = 1'b0;
        wait_flag("seq_done", 1'b1);
        check("seq_cpu_reset", 32'(cpu_reset), 32'd0);
        check("seq_debug", 32'(debug), 32'd0);
        check("seq_strobes", 32'(st_addr.size()), 32'd2);
        if (st_addr.size() == 2) begin
            check("seq_addr0", st_addr[0], 32'h0);
            check("seq_data0", st_data[0], 32'h3C010001);
            check("seq_addr1", st_addr[1], 32'h4);
            check("seq_data1", st_data[1], 32'hDEADBEEF);
            check("seq_spacing", 32'(st_cyc[1] - st_cyc[0]), 32'd5);
        end
`else
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_flags", {29'd0, busy, done, error}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        st_addr.delete(); st_data.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hF5);
        wait_flag("cs_done", 1'b1);
        check("cs_error", 32'(error), 32'd0);
        check("cs_cpu_reset", 32'(cpu_reset), 32'd0);
        check("cs_strobes", 32'(st_addr.size()), 32'd1);
        if (st_addr.size() == 1) check("cs_data", st_data[0], 32'h04030201);

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hF4);
        wait_flag("bad_error", 1'b0);
        check("bad_done", 32'(done), 32'd0);
        check("bad_cpu_reset", 32'(cpu_reset), 32'd1);
        check("bad_strobes", 32'(st_addr.size()), 32'd2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
